sad_min_search: RTL

- Parametrised SAD/min-search engine for the MEMC motion-estimation datapath. Successor to the fixed 8-bit, fixed-block SAD path in the hex search.
- Consumes a stream of (current, reference) pixel pairs grouped into candidates. Accumulates SAD per candidate and tracks the minimum across one search.
- Presents the winning candidate tag, its SAD and its index on a valid/ready output.
- Sits between the SRAM controller's pixel stream and the search-pattern controller. Block size, pixel width and tag width are generalised; optional early termination.

---
 rtl/sad_min_search_if.sv | 36 +++
 rtl/sad_min_search.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/sad_min_search_if.sv
// Pixel-pair stream and search-result handshake for sad_min_search.
// The engine takes the slave modport; the pixel source/result consumer take master.
interface sad_min_search_if #(
  parameter int PIX_W    = 8,
  parameter int BLK_LOG2 = 6,
  parameter int MV_W     = 8,
  parameter int IDX_W    = 5
);
  localparam int SAD_W = PIX_W + BLK_LOG2;

  logic             pix_valid;
  logic             pix_ready;
  logic [PIX_W-1:0] cur_pix;
  logic [PIX_W-1:0] ref_pix;
  logic [MV_W-1:0]  cand_mv;
  logic             pix_last;
  logic             search_last;
  logic             best_valid;
  logic             best_ready;
  logic [MV_W-1:0]  best_mv;
  logic [SAD_W-1:0] best_sad;
  logic [IDX_W-1:0] best_idx;
  logic [IDX_W-1:0] cand_cnt;
  logic             busy;
  logic             err;

  modport master (
    output pix_valid, cur_pix, ref_pix, cand_mv, pix_last, search_last, best_ready,
    input  pix_ready, best_valid, best_mv, best_sad, best_idx, cand_cnt, busy, err
  );

  modport slave (
    input  pix_valid, cur_pix, ref_pix, cand_mv, pix_last, search_last, best_ready,
    output pix_ready, best_valid, best_mv, best_sad, best_idx, cand_cnt, busy, err
  );
endinterface

// File: rtl/sad_min_search.sv
// SAD accumulator with minimum-SAD candidate tracking across one search.
// Optional early termination of losing candidates: SAD_MIN_SEARCH_EARLY_TERM_EN.
module sad_min_search #(
  parameter int PIX_W    = 8,
  parameter int BLK_LOG2 = 6,
  parameter int MV_W     = 8,
  parameter int IDX_W    = 5
) (
  input  logic             clk,
  input  logic             rst,
  sad_min_search_if.slave  bus
`ifdef SAD_MIN_SEARCH_EARLY_TERM_EN
  ,
  output logic [IDX_W-1:0] early_cnt
`endif
);
  localparam int SAD_W = PIX_W + BLK_LOG2;
  // BLK_LOG2=0 still needs a 1-bit counter; it simply stays at zero.
  localparam int CNT_W = (BLK_LOG2 > 0) ? BLK_LOG2 : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((1 << BLK_LOG2) - 1);

  typedef enum logic [1:0] {ACCUM, CMP, OUT} state_t;

  state_t           state;
  logic [SAD_W-1:0] acc;
  logic [SAD_W-1:0] cand_sad;
  logic [CNT_W-1:0] pix_cnt;
  logic [MV_W-1:0]  cur_mv;
  logic             last_q;
  logic             first_cand;
  logic             pix_ready_q;
  logic             best_valid_q;
  logic [MV_W-1:0]  best_mv_q;
  logic [SAD_W-1:0] best_sad_q;
  logic [IDX_W-1:0] best_idx_q;
  logic [IDX_W-1:0] cand_cnt_q;
  logic             busy_q;
  logic             err_q;
`ifdef SAD_MIN_SEARCH_EARLY_TERM_EN
  logic             rejected;
`endif

  logic             beat;
  logic [PIX_W:0]   diff_wide;
  logic [PIX_W-1:0] diff;
  logic [SAD_W-1:0] acc_sum;
  logic             take_best;

  always_comb begin
    beat      = bus.pix_valid & pix_ready_q;
    diff_wide = '0;
    if (bus.cur_pix >= bus.ref_pix)
      diff_wide = {1'b0, bus.cur_pix} - {1'b0, bus.ref_pix};
    else
      diff_wide = {1'b0, bus.ref_pix} - {1'b0, bus.cur_pix};
    diff      = diff_wide[PIX_W-1:0];
    acc_sum   = acc + SAD_W'(diff);
    // Strict compare: a tie keeps the earlier candidate.
    take_best = first_cand | (cand_sad < best_sad_q);
`ifdef SAD_MIN_SEARCH_EARLY_TERM_EN
    take_best = take_best & ~rejected;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ACCUM;
      acc          <= '0;
      cand_sad     <= '0;
      pix_cnt      <= '0;
      cur_mv       <= '0;
      last_q       <= 1'b0;
      first_cand   <= 1'b1;
      pix_ready_q  <= 1'b1;
      best_valid_q <= 1'b0;
      best_mv_q    <= '0;
      best_sad_q   <= '0;
      best_idx_q   <= '0;
      cand_cnt_q   <= '0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
`ifdef SAD_MIN_SEARCH_EARLY_TERM_EN
      rejected     <= 1'b0;
      early_cnt    <= '0;
`endif
    end else begin
      case (state)
        ACCUM: begin
          if (beat) begin
            pix_cnt <= (pix_cnt == LAST_CNT) ? '0 : pix_cnt + 1'b1;
            if (pix_cnt == '0)
              cur_mv <= bus.cand_mv;
            busy_q <= 1'b1;
            if (bus.pix_last != (pix_cnt == LAST_CNT))
              err_q <= 1'b1;
`ifdef SAD_MIN_SEARCH_EARLY_TERM_EN
            // Once rejected the accumulator is frozen; its SAD is never used.
            if (!rejected) begin
              acc <= acc_sum;
              if (!first_cand && (acc_sum >= best_sad_q))
                rejected <= 1'b1;
            end
`else
            acc <= acc_sum;
`endif
            if (bus.pix_last) begin
              cand_sad    <= acc_sum;
              last_q      <= bus.search_last;
              pix_ready_q <= 1'b0;
              state       <= CMP;
            end
          end
        end

        CMP: begin
          if (take_best) begin
            best_mv_q  <= cur_mv;
            best_sad_q <= cand_sad;
            best_idx_q <= cand_cnt_q;
          end
          if (cand_cnt_q == '1)
            err_q <= 1'b1;
          else
            cand_cnt_q <= cand_cnt_q + 1'b1;
`ifdef SAD_MIN_SEARCH_EARLY_TERM_EN
          if (rejected && (early_cnt != '1))
            early_cnt <= early_cnt + 1'b1;
          rejected <= 1'b0;
`endif
          first_cand <= 1'b0;
          acc        <= '0;
          pix_cnt    <= '0;
          if (last_q) begin
            best_valid_q <= 1'b1;
            state        <= OUT;
          end else begin
            pix_ready_q <= 1'b1;
            state       <= ACCUM;
          end
        end

        OUT: begin
          if (bus.best_ready) begin
            best_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            first_cand   <= 1'b1;
            cand_cnt_q   <= '0;
`ifdef SAD_MIN_SEARCH_EARLY_TERM_EN
            early_cnt    <= '0;
`endif
            pix_ready_q  <= 1'b1;
            state        <= ACCUM;
          end
        end

        default: begin
          pix_ready_q  <= 1'b1;
          best_valid_q <= 1'b0;
          state        <= ACCUM;
        end
      endcase
    end
  end

  assign bus.pix_ready  = pix_ready_q;
  assign bus.best_valid = best_valid_q;
  assign bus.best_mv    = best_mv_q;
  assign bus.best_sad   = best_sad_q;
  assign bus.best_idx   = best_idx_q;
  assign bus.cand_cnt   = cand_cnt_q;
  assign bus.busy       = busy_q;
  assign bus.err        = err_q;
endmodule
